// File: rtl/wgmt_sched_pkg.sv
// Shared definitions for the WGMT round-robin scheduler: FSM state encoding
// and the default field widths used by the scheduler and the WGMT bench.
package wgmt_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W_MT  = 11;
  localparam int DEF_W_NT  = 16;
  localparam int DEF_W_GAP = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_GAP   = 2'd3;

endpackage

// File: rtl/wgmt_sched_if.sv
// Bundle of requester-side and WGMT-side signals around the scheduler.
// slave = the scheduler, master = requesters plus the WGMT end_PW source.
interface wgmt_sched_if
  import wgmt_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W_MT  = DEF_W_MT,
  parameter int W_NT  = DEF_W_NT,
  parameter int W_GAP = DEF_W_GAP
);

  logic [N_REQ-1:0]      req;
  logic [N_REQ*W_MT-1:0] mt_in;
  logic [N_REQ*W_NT-1:0] nt_in;
  logic [W_GAP-1:0]      gap_cyc;
  logic                  abort;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      done;
  logic                  err;
  logic                  busy;
  logic                  wg_st;
  logic [W_MT-1:0]       wg_MT;
  logic [W_NT-1:0]       wg_NTclk;
  logic                  wg_end_PW;

  modport slave (
    input  req, mt_in, nt_in, gap_cyc, abort, wg_end_PW,
    output gnt, done, err, busy, wg_st, wg_MT, wg_NTclk
  );

  modport master (
    output req, mt_in, nt_in, gap_cyc, abort, wg_end_PW,
    input  gnt, done, err, busy, wg_st, wg_MT, wg_NTclk
  );

endinterface

// File: rtl/wgmt_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around. The request vector is doubled and rotated down by ptr so
// a plain lowest-bit priority encoder finds the winner's offset from ptr.
module wgmt_sched_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx
);

  localparam logic [IW:0] N_L = N_REQ[IW:0];

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;

  // rotate, priority-encode the lowest set bit, then map back to an index
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IW-1:0];
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_L) sum = sum - N_L;
    win_idx = sum[IW-1:0];
    win_oh  = '0;
    win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/wgmt_sched.sv
// Round-robin scheduler sharing one WGMT pulse-width generator between
// N_REQ requesters: arbitrate, load operands, fire st, wait for end_PW,
// report done (or err on abort), then hold off for a guard gap.
//
//   state | meaning
//   IDLE  | arbitrating; WGMT free
//   START | operands loaded, st high for this single cycle
//   RUN   | pulse in progress, waiting for end_PW
//   GAP   | guard gap after a pulse, requests ignored
module wgmt_sched
  import wgmt_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W_MT  = DEF_W_MT,
  parameter int W_NT  = DEF_W_NT,
  parameter int W_GAP = DEF_W_GAP
) (
  input logic         clk,
  input logic         rst_n,
  wgmt_sched_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    w_idx;
  logic [W_GAP-1:0] gap_cnt;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] done_r;
  logic             err_r;
  logic             st_r;
  logic [W_MT-1:0]  mt_r;
  logic [W_NT-1:0]  nt_r;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    ptr_nxt;
  logic             kill;
  logic             run_end;

  wgmt_sched_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  // abort outranks end_PW; end_PW is only honoured once the pulse is running
  assign kill    = bus.abort && (state == ST_START || state == ST_RUN);
  assign run_end = bus.wg_end_PW && !bus.abort && (state == ST_RUN);
  assign ptr_nxt = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;

  // FSM, operand registers, round-robin pointer and guard-gap down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      w_idx   <= '0;
      gap_cnt <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      err_r   <= 1'b0;
      st_r    <= 1'b0;
      mt_r    <= '0;
      nt_r    <= '0;
    end else begin
      st_r   <= 1'b0;
      done_r <= '0;
      err_r  <= 1'b0;
      if (kill || run_end) begin
        gnt_r  <= '0;
        ptr    <= ptr_nxt;
        done_r <= run_end ? gnt_r : '0;
        err_r  <= kill;
        // a zero gap skips GAP entirely so the next arbitration is immediate
        if (bus.gap_cyc == '0) begin
          state <= ST_IDLE;
        end else begin
          state   <= ST_GAP;
          gap_cnt <= bus.gap_cyc - 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (|bus.req) begin
              w_idx <= pick_idx;
              gnt_r <= pick_oh;
              mt_r  <= bus.mt_in[int'(pick_idx) * W_MT +: W_MT];
              nt_r  <= bus.nt_in[int'(pick_idx) * W_NT +: W_NT];
              st_r  <= 1'b1;
              state <= ST_START;
            end
          end
          ST_START: state <= ST_RUN;
          ST_RUN:   state <= ST_RUN;
          ST_GAP: begin
            if (gap_cnt == '0) state <= ST_IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.wg_st    = st_r;
  assign bus.wg_MT    = mt_r;
  assign bus.wg_NTclk = nt_r;

endmodule

// File: tb/tb_wgmt_sched.sv
// Directed bench for wgmt_sched: the WGMT is modelled by driving end_PW
// from the stimulus sequence; expected values are hand-computed.
module tb_wgmt_sched;

  localparam int N  = 4;
  localparam int WM = 11;
  localparam int WN = 16;
  localparam int WG = 8;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  logic [WM-1:0] mt_tab [N];
  logic [WN-1:0] nt_tab [N];

  wgmt_sched_if #(.N_REQ(N), .W_MT(WM), .W_NT(WN), .W_GAP(WG)) bus ();

  wgmt_sched #(.N_REQ(N), .W_MT(WM), .W_NT(WN), .W_GAP(WG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait (bounded) for a grant, then run a full pulse and check completion
  task automatic serve(input int exp, input bit chk_idle);
    int idle;
    bit got;
    idle = 1;
    got  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.gnt != '0) begin
        got = 1'b1;
        break;
      end
      idle++;
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (chk_idle) chk("idle_cycles", 32'(idle), 32'd4);
    chk("gnt", 32'(bus.gnt), 32'(1 << exp));
    chk("st_high", 32'(bus.wg_st), 32'd1);
    chk("wg_MT", 32'(bus.wg_MT), 32'(mt_tab[exp]));
    chk("wg_NTclk", 32'(bus.wg_NTclk), 32'(nt_tab[exp]));
    tick();
    chk("st_one_cycle", 32'(bus.wg_st), 32'd0);
    repeat (8) tick();
    bus.wg_end_PW = 1'b1;
    tick();
    bus.wg_end_PW = 1'b0;
    chk("done", 32'(bus.done), 32'(1 << exp));
    chk("gnt_clear", 32'(bus.gnt), 32'd0);
    chk("err_quiet", 32'(bus.err), 32'd0);
  endtask

  initial begin
    int got;
    nvec = 0;
    nerr = 0;
    mt_tab = '{11'd16, 11'd40, 11'd77, 11'd2047};
    nt_tab = '{16'd20, 16'd300, 16'd4660, 16'd65535};
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.abort     = 1'b0;
    bus.wg_end_PW = 1'b0;
    bus.gap_cyc   = 8'd3;
    for (int i = 0; i < N; i++) begin
      bus.mt_in[i*WM +: WM] = mt_tab[i];
      bus.nt_in[i*WN +: WN] = nt_tab[i];
    end

    // reset state
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_st", 32'(bus.wg_st), 32'd0);
    chk("rst_MT", 32'(bus.wg_MT), 32'd0);
    chk("rst_NT", 32'(bus.wg_NTclk), 32'd0);
    bus.req = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;

    // round-robin fairness with gap 3
    serve(0, 1'b0);
    serve(1, 1'b1);
    serve(2, 1'b1);
    serve(3, 1'b1);
    serve(0, 1'b1);

    // wrap-around: serve 3, then 1001 must go to 0
    bus.req = 4'b1000;
    serve(3, 1'b1);
    bus.req = 4'b1001;
    serve(0, 1'b1);

    // abort on requester 2 five cycles into RUN
    bus.req = 4'b0100;
    got = 0;
    for (int i = 0; i < 50 && bus.gnt == '0; i++) tick();
    chk("abort_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    repeat (4) tick();
    chk("abort_in_run", 32'(bus.gnt), 32'b0100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_err", 32'(bus.err), 32'd1);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    chk("abort_gnt_clear", 32'(bus.gnt), 32'd0);
    chk("abort_busy_gap", 32'(bus.busy), 32'd1);
    bus.req = 4'b0111;
    serve(0, 1'b1);

    // abort and end_PW in the same cycle
    got = 0;
    for (int i = 0; i < 50 && bus.gnt == '0; i++) tick();
    chk("both_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    bus.abort     = 1'b1;
    bus.wg_end_PW = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.wg_end_PW = 1'b0;
    chk("both_err", 32'(bus.err), 32'd1);
    chk("both_done", 32'(bus.done), 32'd0);

    // gap 0, early end_PW ignored, req drop, operand stability
    bus.gap_cyc = 8'd0;
    bus.req     = 4'b0001;
    for (int i = 0; i < 50 && bus.gnt == '0; i++) tick();
    chk("single_gnt", 32'(bus.gnt), 32'b0001);
    chk("single_st", 32'(bus.wg_st), 32'd1);
    chk("single_MT", 32'(bus.wg_MT), 32'd16);
    chk("single_NT", 32'(bus.wg_NTclk), 32'd20);
    bus.wg_end_PW = 1'b1;
    tick();
    bus.wg_end_PW = 1'b0;
    chk("early_end_gnt", 32'(bus.gnt), 32'b0001);
    chk("early_end_done", 32'(bus.done), 32'd0);
    chk("early_end_busy", 32'(bus.busy), 32'd1);
    bus.req = 4'b0000;
    bus.mt_in[0 +: WM] = 11'd5;
    tick();
    tick();
    chk("drop_gnt_held", 32'(bus.gnt), 32'b0001);
    chk("mt_stable", 32'(bus.wg_MT), 32'd16);
    bus.wg_end_PW = 1'b1;
    tick();
    bus.wg_end_PW = 1'b0;
    chk("drop_done", 32'(bus.done), 32'b0001);
    chk("gap0_idle", 32'(bus.busy), 32'd0);
    bus.mt_in[0 +: WM] = mt_tab[0];
    bus.req = 4'b0010;
    tick();
    chk("gap0_b2b_gnt", 32'(bus.gnt), 32'b0010);

    // reset mid-run, then ptr restarts from 0
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_st", 32'(bus.wg_st), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_MT", 32'(bus.wg_MT), 32'd0);
    bus.req = 4'b0100;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0100);
    chk("post_rst_MT", 32'(bus.wg_MT), 32'd77);
    tick();
    bus.wg_end_PW = 1'b1;
    tick();
    bus.wg_end_PW = 1'b0;
    chk("post_rst_done", 32'(bus.done), 32'b0100);
    bus.req = 4'b0000;

    // abort while idle has no effect
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_err", 32'(bus.err), 32'd0);
    chk("idle_abort_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
